if_id_buffer: RTL

- Decoupling buffer between instruction fetch and decode.
- Captures each fetched (PC, instruction) pair when the I-cache response completes.
- Holds pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- Discards all contents on a control-flow flush, and supplies a NOP whenever decode would otherwise see a bubble.

---
 rtl/if_id_buffer_pkg.sv | 25 ++
 rtl/if_id_buffer_if.sv | 36 +++
 rtl/if_id_buffer.sv | 89 ++++++++
 3 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared LC-3b fetch/decode types for the IF/ID buffer.
// Holds the word type, the NOP encoding injected on bubbles, and the buffered packet layout.
// Imported by the interface and the buffer.
package if_id_buffer_pkg;

  typedef logic [15:0] lc3b_word;

  // BR with nzp=000 never branches, so it is a harmless bubble for decode.
  localparam lc3b_word NOP_INSTR = 16'h0000;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    lc3b_word pc;
    lc3b_word instr;
  } lc3b_fetch_pkt;

  // Clears a packet to the value presented when nothing is buffered.
  function automatic lc3b_fetch_pkt empty_pkt();
    lc3b_fetch_pkt p;
    p.pc    = 16'h0000;
    p.instr = NOP_INSTR;
    return p;
  endfunction

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the IF/ID buffer.
// master = the fetch/decode environment driving requests; slave = the buffer itself.
// DEPTH must match the DEPTH of the buffer instance it is connected to.
interface if_id_buffer_if #(
  parameter int DEPTH = 2
);
  import if_id_buffer_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  // Fetch side
  logic             in_valid;
  lc3b_word         in_pc;
  lc3b_word         in_instr;
  logic             in_ready;
  // Control flow
  logic             flush;
  // Decode side
  logic             out_ready;
  logic             out_valid;
  lc3b_word         out_pc;
  lc3b_word         out_instr;
  logic             out_nop;
  logic [PTR_W:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_nop, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_nop, count
  );

endinterface

// File: rtl/if_id_buffer.sv
// Purpose: small circular FIFO decoupling instruction fetch from decode, NOP on bubbles.
// Latency: one cycle from push to visibility at the head; no empty bypass.
// Backpressure: in_ready depends only on occupancy; flush discards everything incl. same-cycle traffic.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic           clk,
  input logic           reset,
  if_id_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  lc3b_fetch_pkt    r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  lc3b_fetch_pkt    w_in_pkt;
  lc3b_fetch_pkt    w_head_pkt;

  // Status comes purely from registered occupancy, so in_ready has no path from out_ready.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // A flush cancels both sides of the handshake in the same cycle.
  assign w_push = bus.in_valid && !w_full  && !bus.flush;
  assign w_pop  = !w_empty && bus.out_ready && !bus.flush;

  assign w_in_pkt.pc    = bus.in_pc;
  assign w_in_pkt.instr = bus.in_instr;

  // Present the head entry, or a clean NOP/PC=0 bubble when nothing is buffered.
  always_comb begin
    w_head_pkt = empty_pkt();
    if (!w_empty) begin
      w_head_pkt = r_mem[r_head];
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.out_nop   = w_empty;
  assign bus.out_pc    = w_head_pkt.pc;
  assign bus.out_instr = w_head_pkt.instr;
  assign bus.count     = r_count;

  // Storage write; contents need no reset because the count qualifies every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= w_in_pkt;
    end
  end

  // Pointer and occupancy update; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Occupancy must never exceed capacity.
  a_count_bound: assert property (@(posedge clk) disable iff (reset) r_count <= CNT_FULL);

endmodule
